inst_fetch_ctrl: RTL and testbench
==================================

Name: inst_fetch_ctrl

Overview:
- Fetch-side controller that sits between the pipeline's IF stage and the 128-bit line-based instruction memory.
- Holds one 4-word line buffer with a tag and serves hits combinationally.
- On a miss, sequences a line request to memory, waits for a fresh ready, fills the buffer and replays the fetch.
- Provides flush/invalidate control, a wait timeout with a sticky error flag, and hit/miss counters.

Parameters:
- MAX_WAIT, 16: max cycles spent in WAIT before declaring a memory error (range 2..255).
- CNT_W, 16: width of hit_count/miss_count (wrap at 2^CNT_W).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- pc  in  32  fetch byte address; line tag = pc[31:4], word select = pc[3:2], pc[1:0] ignored
- pc_valid  in  1  fetch request this cycle
- flush  in  1  abort in-flight miss (branch redirect)
- inval  in  1  clear line buffer valid bit
- inst  out  32  fetched instruction; 0 when inst_valid=0
- inst_valid  out  1  inst is valid for current pc
- fetch_stall  out  1  pipeline must hold pc
- mem_addr  out  32  line address to memory, {tag,4'b0}
- mem_qdata  in  128  line data; [127:96]=word0 (lowest address) ... [31:0]=word3
- mem_ready  in  1  memory line data valid for mem_addr
- mem_err  out  1  sticky timeout error
- hit_count  out  CNT_W  hits served
- miss_count  out  CNT_W  misses started

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, buf_valid=0, buf_tag=0, buf_data=0, mem_addr=0, wait_cnt=0, mem_err=0, both counters=0. Resulting outputs: inst=0, inst_valid=0, fetch_stall=0. Reset mid-WAIT discards the pending fill.
- hit = buf_valid && buf_tag==pc[31:4].
- States: IDLE, WAIT, ERR.
- IDLE, hit:
  - Combinational: inst_valid=pc_valid, inst=selected buf word, fetch_stall=0.
  - Registered: hit_count++ on each cycle with pc_valid && hit.
- IDLE, miss (pc_valid && !hit): fetch_stall=1 combinationally, inst_valid=0. At the edge: mem_addr<={pc[31:4],4'b0}, req_tag<=pc[31:4], wait_cnt<=0, miss_count++, state<=WAIT.
- IDLE, no pc_valid: outputs 0; mem_addr holds its last value and is never driven from an unrequested pc.
- WAIT:
  - Outputs: fetch_stall=1, inst_valid=0; mem_addr held stable.
  - wait_cnt increments each cycle.
  - mem_ready is ignored while wait_cnt==0, because the memory's ready may be stale for the previous line.
  - mem_ready && wait_cnt>=1: buf_data<=mem_qdata, buf_tag<=req_tag, buf_valid<=1, state<=IDLE. The replayed fetch hits the next cycle.
  - Timeout: wait_cnt==MAX_WAIT-1 without a qualifying ready gives state<=ERR, mem_err<=1.
- ERR: fetch_stall=1, inst_valid=0, mem_err=1; exits only via reset.
- flush:
  - In WAIT: state<=IDLE next edge and the in-flight data is dropped, even if mem_ready is high the same cycle; flush wins. buf_valid is unchanged.
  - In IDLE: no effect; the buffer stays valid (memory is read-only).
  - In ERR: ignored.
- inval: buf_valid<=0 at the edge.
  - Coincident with an IDLE hit: the current cycle is still served; the next access misses.
  - Coincident with a fill in WAIT: the fill wins (buf_valid=1).
- flush and inval together in WAIT: both apply; state→IDLE, buf_valid=0.
- pc change during WAIT: ignored. After returning to IDLE, the new pc is re-evaluated and a second miss may start.
- Counters wrap modulo 2^CNT_W silently.
- Miss latency with a memory that raises ready 2 cycles after an address change: pc_valid miss at cycle T → WAIT T+1..T+3 (ready seen at T+3) → inst_valid at T+4.

Test Plan:
- Cold miss: reset, then pc=0x0000_0008, pc_valid=1 held, with a bench memory of 2-cycle ready and word k = 0x1000+k. Required: fetch_stall high for 4 cycles, mem_addr=0x0, then inst=0x1002 with inst_valid=1, miss_count=1.
- Same-line hits: after the fill, pc=0x0,0x4,0xC in consecutive cycles → inst 0x1000, 0x1001, 0x1003; no stalls; hit_count +3; mem_addr unchanged.
- Stale ready: switch pc to 0x10 while the bench holds mem_ready=1 from the previous line during WAIT cycle 0. Required: no capture; the fill occurs only on the fresh ready; buffer holds line 0x10.
- Flush mid-miss: miss to 0x20, assert flush at WAIT cycle 2 together with mem_ready=1. Required: state IDLE, buffer still holds the old tag; the next pc=0x20 starts a new miss (miss_count +1).
- Timeout: MAX_WAIT=4, memory never ready. Required: mem_err=1 exactly 4 cycles after entering WAIT; fetch_stall stays 1; flush has no effect; rst_n=0 clears everything.
- Invalidate and wrap: inval on a hit cycle → that cycle inst_valid=1, next same-line fetch misses. With CNT_W=4, 16 misses → miss_count returns to 0.

Source files
------------

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: single-line instruction buffer with miss sequencing, flush, timeout and hit/miss counters
module inst_fetch_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc,
  input  logic             pc_valid,
  input  logic             flush,
  input  logic             inval,
  output logic [31:0]      inst,
  output logic             inst_valid,
  output logic             fetch_stall,
  output logic [31:0]      mem_addr,
  input  logic [127:0]     mem_qdata,
  input  logic             mem_ready,
  output logic             mem_err,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);
  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;
  state_t state, state_nx;
  logic buf_valid;
  logic [27:0] buf_tag, req_tag;
  logic [127:0] buf_data;
  logic [7:0] wait_cnt;
  logic hit, idle, miss, fill, drop, tout;
  logic [31:0] word;
  always_comb begin
    idle = state == IDLE;
    hit = buf_valid && buf_tag == pc[31:4];
    word = pc[3] ? (pc[2] ? buf_data[31:0] : buf_data[63:32])
                 : (pc[2] ? buf_data[95:64] : buf_data[127:96]);
    inst_valid = idle && pc_valid && hit;
    fetch_stall = !idle || (pc_valid && !hit);
    inst = inst_valid ? word : '0;
    miss = idle && pc_valid && !hit;
    drop = state == WAIT && flush;
    // the first WAIT cycle's ready may still belong to the previous line
    fill = state == WAIT && !flush && mem_ready && wait_cnt != 8'd0;
    tout = state == WAIT && !flush && !fill && wait_cnt == 8'(MAX_WAIT - 1);
    state_nx = miss ? WAIT : (drop || fill) ? IDLE : tout ? ERR : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      buf_valid <= 1'b0;
      buf_tag <= '0;
      req_tag <= '0;
      buf_data <= '0;
      mem_addr <= '0;
      wait_cnt <= '0;
      mem_err <= 1'b0;
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      state <= state_nx;
      wait_cnt <= miss ? 8'd0 : (state == WAIT) ? wait_cnt + 8'd1 : wait_cnt;
      if (miss) begin
        mem_addr <= {pc[31:4], 4'b0};
        req_tag <= pc[31:4];
        miss_count <= miss_count + CNT_W'(1);
      end
      if (inst_valid) hit_count <= hit_count + CNT_W'(1);
      if (fill) begin
        buf_data <= mem_qdata;
        buf_tag <= req_tag;
        buf_valid <= 1'b1;
      end else if (inval) buf_valid <= 1'b0;
      if (tout) mem_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: table vectors, directed corner sequences and random traffic against a behavioural model
module tb_inst_fetch_ctrl;
  localparam int MW = 4;
  localparam int CW = 4;
  logic clk = 0, rst_n = 0, pc_valid = 0, flush = 0, inval = 0, mem_ready = 0;
  logic [31:0] pc = 0;
  logic [127:0] mem_qdata = 0;
  logic [31:0] inst, mem_addr;
  logic inst_valid, fetch_stall, mem_err;
  logic [CW-1:0] hit_count, miss_count;
  inst_fetch_ctrl #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_valid(pc_valid), .flush(flush), .inval(inval),
    .inst(inst), .inst_valid(inst_valid), .fetch_stall(fetch_stall), .mem_addr(mem_addr),
    .mem_qdata(mem_qdata), .mem_ready(mem_ready), .mem_err(mem_err),
    .hit_count(hit_count), .miss_count(miss_count));
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int ms = 0, mwc = 0, mhit = 0, mmiss = 0;
  bit mbv = 0, merr = 0;
  logic [27:0] mtag = 0, mreq = 0;
  logic [31:0] maddr = 0;
  bit mode_auto = 1, frc_rdy = 0;
  logic [31:0] frc_line = 0;
  int age = 99, dly = 2;
  logic [31:0] s_inst;
  bit s_v, s_st;
  typedef struct {logic [31:0] pc; bit pv; logic [31:0] ei; bit ev; bit es;} vec_t;
  vec_t tbl[8];
  function automatic logic [31:0] wd(logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction
  function automatic logic [127:0] line(logic [31:0] a);
    return {wd(a), wd(a + 4), wd(a + 8), wd(a + 12)};
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic mstep();
    bit h = mbv && mtag == pc[31:4];
    if (!rst_n) begin
      ms = 0; mbv = 0; mtag = 0; mreq = 0; maddr = 0; mwc = 0; merr = 0; mhit = 0; mmiss = 0;
      return;
    end
    case (ms)
      0: begin
        if (pc_valid && h) mhit++;
        if (pc_valid && !h) begin
          maddr = {pc[31:4], 4'b0}; mreq = pc[31:4]; mwc = 0; mmiss++; ms = 1;
        end
        if (inval) mbv = 0;
      end
      1: begin
        if (flush) begin
          ms = 0;
          if (inval) mbv = 0;
        end else if (mem_ready && mwc >= 1) begin
          mtag = mreq; mbv = 1; ms = 0;
        end else begin
          if (mwc == MW - 1) begin ms = 2; merr = 1; end
          if (inval) mbv = 0;
        end
        mwc++;
      end
      default: if (inval) mbv = 0;
    endcase
  endtask
  task automatic cyc();
    bit eh, ev, est, miss_now;
    mem_ready = mode_auto ? (age >= dly) : frc_rdy;
    mem_qdata = mode_auto ? line(mem_addr) : line(frc_line);
    #2;
    eh = mbv && mtag == pc[31:4];
    ev = ms == 0 && pc_valid && eh;
    est = ms != 0 || (pc_valid && !eh);
    s_inst = inst; s_v = inst_valid; s_st = fetch_stall;
    chk("inst", inst, ev ? wd({pc[31:2], 2'b0}) : 32'h0);
    chk("inst_valid", 32'(inst_valid), 32'(ev));
    chk("fetch_stall", 32'(fetch_stall), 32'(est));
    chk("mem_addr", mem_addr, maddr);
    chk("mem_err", 32'(mem_err), 32'(merr));
    chk("hit_count", 32'(hit_count), 32'(mhit % (1 << CW)));
    chk("miss_count", 32'(miss_count), 32'(mmiss % (1 << CW)));
    miss_now = rst_n && ms == 0 && pc_valid && !eh;
    @(posedge clk);
    mstep();
    age = miss_now ? 0 : age + 1;
    #1;
  endtask
  task automatic do_reset();
    rst_n = 0;
    @(posedge clk);
    mstep();
    #1;
    rst_n = 1;
  endtask
  task automatic wait_valid(string nm);
    int n = 0;
    do begin cyc(); n++; end while (!s_v && n < 12);
    checks++;
    if (!s_v) begin
      errors++;
      $display("FAIL %s: inst_valid got 0 expected 1 within 12 cycles", nm);
    end
  endtask
  initial begin
    logic [CW-1:0] mc;
    tbl[0] = '{32'h8, 1, 32'h0, 0, 1};
    tbl[1] = '{32'h8, 1, 32'h0, 0, 1};
    tbl[2] = '{32'h8, 1, 32'h0, 0, 1};
    tbl[3] = '{32'h8, 1, 32'h0, 0, 1};
    tbl[4] = '{32'h8, 1, 32'h1002, 1, 0};
    tbl[5] = '{32'h0, 1, 32'h1000, 1, 0};
    tbl[6] = '{32'h4, 1, 32'h1001, 1, 0};
    tbl[7] = '{32'hC, 1, 32'h1003, 1, 0};
    do_reset();
    #1;
    chk("rst_inst", inst, 0);
    chk("rst_valid", 32'(inst_valid), 0);
    chk("rst_stall", 32'(fetch_stall), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_hits", 32'(hit_count), 0);
    cyc();
    foreach (tbl[i]) begin
      pc = tbl[i].pc; pc_valid = tbl[i].pv;
      cyc();
      chk($sformatf("tbl%0d_inst", i), s_inst, tbl[i].ei);
      chk($sformatf("tbl%0d_valid", i), 32'(s_v), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_stall", i), 32'(s_st), 32'(tbl[i].es));
    end
    chk("cold_miss_count", 32'(miss_count), 1);
    chk("cold_hit_count", 32'(hit_count), 4);
    chk("cold_mem_addr", mem_addr, 0);
    mode_auto = 0; frc_rdy = 1; frc_line = 32'h0;
    pc = 32'h10; cyc();
    cyc();
    frc_rdy = 0; cyc();
    chk("stale_no_capture", 32'(s_st), 1);
    frc_rdy = 1; frc_line = 32'h10; cyc();
    cyc();
    chk("stale_fill_valid", 32'(s_v), 1);
    chk("stale_fill_inst", s_inst, 32'h1004);
    frc_rdy = 0; pc = 32'h20; cyc();
    cyc(); cyc();
    flush = 1; frc_rdy = 1; frc_line = 32'h20; cyc();
    flush = 0; frc_rdy = 0; pc = 32'h10; cyc();
    chk("flush_old_tag_valid", 32'(s_v), 1);
    chk("flush_old_tag_inst", s_inst, 32'h1004);
    mc = miss_count; pc = 32'h20; mode_auto = 1; cyc();
    chk("flush_remiss_stall", 32'(s_st), 1);
    chk("flush_remiss_count", 32'(miss_count), 32'(mc + 1'b1));
    wait_valid("flush_refill");
    chk("flush_refill_inst", s_inst, 32'h1008);
    pc = 32'h0; wait_valid("inval_fill");
    inval = 1; cyc();
    chk("inval_same_cycle_valid", 32'(s_v), 1);
    chk("inval_same_cycle_inst", s_inst, 32'h1000);
    inval = 0; cyc();
    chk("inval_next_miss", 32'(s_st), 1);
    wait_valid("inval_refill");
    mode_auto = 0; frc_rdy = 0; pc = 32'h40; cyc();
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("timeout_err_w%0d", k), 32'(mem_err), 32'(k == 3));
    end
    flush = 1; cyc();
    chk("err_flush_stall", 32'(s_st), 1);
    chk("err_flush_err", 32'(mem_err), 1);
    flush = 0;
    do_reset();
    chk("err_rst_err", 32'(mem_err), 0);
    chk("err_rst_miss", 32'(miss_count), 0);
    pc_valid = 0; cyc();
    chk("err_rst_stall", 32'(s_st), 0);
    mode_auto = 1; pc_valid = 1;
    for (int i = 0; i < 16; i++) begin
      pc = i << 4;
      wait_valid("wrap_fill");
    end
    chk("wrap_miss_count", 32'(miss_count), 0);
    for (int i = 0; i < 800; i++) begin
      rst_n = ($urandom % 60) != 0;
      pc = ($urandom_range(0, 3) << 4) | ($urandom % 16);
      pc_valid = ($urandom % 4) != 0;
      flush = ($urandom % 10) == 0;
      inval = ($urandom % 12) == 0;
      if (age == 0) dly = $urandom_range(1, 4);
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
